// File: rtl/mac_vec_with_mem_if.sv
// Command/status handshake of the vector MAC: operation parameters in,
// completion and status flags out. Memory bus pins stay on the module itself.
interface mac_vec_with_mem_if #(
   parameter int ADDR_W = 8,
   parameter int LEN_W  = 4
);
   logic              start;
   logic              done;
   logic              busy;
   logic              overflow;
   logic [ADDR_W-1:0] a_addr;
   logic [ADDR_W-1:0] kernel_addr;
   logic [ADDR_W-1:0] output_addr;
   logic [LEN_W-1:0]  vec_len;
   logic              signed_mode;
   logic              acc_mode;

   modport slave (
      input  start, a_addr, kernel_addr, output_addr, vec_len, signed_mode, acc_mode,
      output done, busy, overflow
   );

   modport master (
      output start, a_addr, kernel_addr, output_addr, vec_len, signed_mode, acc_mode,
      input  done, busy, overflow
   );
endinterface

// File: rtl/mac_vec_with_mem.sv
// Memory-attached packed-lane vector MAC: fetches vec_len operand/kernel pairs
// over a shared tri-state bus, accumulates lane dot products, writes the result.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | bus released, waiting for start
// S_RD_BIAS | reading existing output word as initial accumulator
// S_RD_A    | reading operand word a_addr+i
// S_RD_K    | reading kernel word kernel_addr+i
// S_MAC     | one-cycle lane multiply-accumulate, bus released
// S_WR      | writing accumulator to output_addr
// S_DONE    | result written, done high until next start
module mac_vec_with_mem #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 32,
   parameter int LANE_W     = 8,
   parameter int LEN_W      = 4,
   parameter int MEM_RD_LAT = 1
) (
   input  logic                clk,
   input  logic                rst,
   mac_vec_with_mem_if.slave   ctl,
   output logic                mem_w,
   output logic                mem_sel,
   inout  wire  [ADDR_W-1:0]   address_bus,
   inout  wire  [DATA_W-1:0]   data_bus
);
   localparam int LANES  = DATA_W / LANE_W;
   localparam int PROD_W = 2*LANE_W + 2;
   localparam int SUM_W  = DATA_W + 2*LANE_W + 2;
   localparam int CNT_W  = (MEM_RD_LAT < 1) ? 1 : $clog2(MEM_RD_LAT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_RD_BIAS, S_RD_A, S_RD_K, S_MAC, S_WR, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   a_base_q, k_base_q, o_addr_q, addr_d;
   logic [LEN_W-1:0]    len_q, idx_q;
   logic [LEN_W:0]      idx_nxt;
   logic                sgn_q, ovf_q;
   logic [DATA_W-1:0]   acc_q, a_word_q, k_word_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                start_ok, rd_last;

   logic signed [LANE_W:0]    a_lane, k_lane;
   logic signed [PROD_W-1:0]  lane_prod;
   logic signed [SUM_W-1:0]   lane_sum, acc_ext, mac_total;
   logic                      mac_ovf;

   assign start_ok = ctl.start && (state_q == S_IDLE || state_q == S_DONE);
   assign rd_last  = (cnt_q == '0);
   assign idx_nxt  = {1'b0, idx_q} + (LEN_W+1)'(1);

   assign ctl.done     = (state_q == S_DONE);
   assign ctl.busy     = (state_q != S_IDLE) && (state_q != S_DONE);
   assign ctl.overflow = ovf_q;

   assign address_bus = mem_sel ? addr_d : 'z;
   assign data_bus    = (mem_sel && mem_w) ? acc_q : 'z;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      mem_sel = 1'b0;
      mem_w   = 1'b0;
      addr_d  = o_addr_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (ctl.start) begin
               if (ctl.acc_mode)           state_d = S_RD_BIAS;
               else if (ctl.vec_len != '0) state_d = S_RD_A;
               else                        state_d = S_WR;
            end
         end
         S_RD_BIAS: begin
            mem_sel = 1'b1;
            if (rd_last) state_d = (len_q != '0) ? S_RD_A : S_WR;
         end
         S_RD_A: begin
            mem_sel = 1'b1;
            addr_d  = a_base_q + ADDR_W'(idx_q);
            if (rd_last) state_d = S_RD_K;
         end
         S_RD_K: begin
            mem_sel = 1'b1;
            addr_d  = k_base_q + ADDR_W'(idx_q);
            if (rd_last) state_d = S_MAC;
         end
         S_MAC: state_d = (idx_nxt < {1'b0, len_q}) ? S_RD_A : S_WR;
         S_WR: begin
            mem_sel = 1'b1;
            mem_w   = 1'b1;
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Lanes get one extra bit (sign or zero) so one signed multiplier covers both modes.
   always_comb begin
      a_lane    = '0;
      k_lane    = '0;
      lane_prod = '0;
      lane_sum  = '0;
      for (int j = 0; j < LANES; j++) begin
         a_lane    = {sgn_q & a_word_q[j*LANE_W+LANE_W-1], a_word_q[j*LANE_W +: LANE_W]};
         k_lane    = {sgn_q & k_word_q[j*LANE_W+LANE_W-1], k_word_q[j*LANE_W +: LANE_W]};
         lane_prod = a_lane * k_lane;
         lane_sum  = lane_sum + {{(SUM_W-PROD_W){lane_prod[PROD_W-1]}}, lane_prod};
      end
      acc_ext   = {{(SUM_W-DATA_W){sgn_q & acc_q[DATA_W-1]}}, acc_q};
      mac_total = acc_ext + lane_sum;
      if (sgn_q) mac_ovf = !((&mac_total[SUM_W-1:DATA_W-1]) || !(|mac_total[SUM_W-1:DATA_W-1]));
      else       mac_ovf = |mac_total[SUM_W-1:DATA_W];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_base_q <= '0;
         k_base_q <= '0;
         o_addr_q <= '0;
         len_q    <= '0;
         sgn_q    <= 1'b0;
         ovf_q    <= 1'b0;
         acc_q    <= '0;
         a_word_q <= '0;
         k_word_q <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
      end else begin
         // Read-hold timer reloads on every state change and counts down to the capture edge.
         if (state_d != state_q)  cnt_q <= CNT_W'(MEM_RD_LAT);
         else if (cnt_q != '0)    cnt_q <= cnt_q - CNT_W'(1);
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_ok) begin
                  a_base_q <= ctl.a_addr;
                  k_base_q <= ctl.kernel_addr;
                  o_addr_q <= ctl.output_addr;
                  len_q    <= ctl.vec_len;
                  sgn_q    <= ctl.signed_mode;
                  ovf_q    <= 1'b0;
                  acc_q    <= '0;
                  idx_q    <= '0;
               end
            end
            S_RD_BIAS: if (rd_last) acc_q    <= data_bus;
            S_RD_A:    if (rd_last) a_word_q <= data_bus;
            S_RD_K:    if (rd_last) k_word_q <= data_bus;
            S_MAC: begin
               acc_q <= mac_total[DATA_W-1:0];
               idx_q <= idx_nxt[LEN_W-1:0];
               if (mac_ovf) ovf_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule
